// File: rtl/core_pkg.sv
// Shared types and encodings for the pipeline hazard controller.
package core_pkg;

  localparam int unsigned RA_W = 5;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_e;

  typedef struct packed {
    logic            valid;
    logic [RA_W-1:0] rd;
    logic [RA_W-1:0] rs1;
    logic [RA_W-1:0] rs2;
    logic            regwrite;
    logic            memread;
  } slot_t;

endpackage

// File: rtl/fwd_sel.sv
// Forwarding select for one ALU operand; M beats W, loads in M cannot forward, x0 never matches.
module fwd_sel
  import core_pkg::*;
(
  input  logic            i_m_valid,
  input  logic            i_m_regwrite,
  input  logic            i_m_memread,
  input  logic [RA_W-1:0] i_m_rd,
  input  logic            i_w_valid,
  input  logic            i_w_regwrite,
  input  logic [RA_W-1:0] i_w_rd,
  input  logic [RA_W-1:0] i_rs,
  output logic [1:0]      o_fwd
);

  logic w_hit_m;
  logic w_hit_w;

  assign w_hit_m = i_m_valid & i_m_regwrite & ~i_m_memread & (i_m_rd != '0) & (i_m_rd == i_rs);
  assign w_hit_w = i_w_valid & i_w_regwrite & (i_w_rd != '0) & (i_w_rd == i_rs);

  always_comb begin
    o_fwd = FWD_RF;
    if (w_hit_m) begin
      o_fwd = FWD_MEM;
    end else if (w_hit_w) begin
      o_fwd = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: shadow E/M/W slots, load-use stalls, redirect flushes, forwarding selects.
module hazard_ctrl
  import core_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             validD,
  input  logic [RA_W-1:0]  rs1D,
  input  logic [RA_W-1:0]  rs2D,
  input  logic [RA_W-1:0]  rdD,
  input  logic             RegWriteD,
  input  logic             MemReadD,
  input  logic             PCSrcM,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  slot_t            r_e, r_m, r_w;
  slot_t            w_d;
  state_e           r_state, w_state_next;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
  logic             w_ldu, w_flush, w_stall;
  logic             w_unused;

  assign w_d = '{valid: validD, rd: rdD, rs1: rs1D, rs2: rs2D,
                 regwrite: RegWriteD, memread: MemReadD};

  assign w_ldu = validD & r_e.valid & r_e.memread & (r_e.rd != '0) &
                 ((r_e.rd == rs1D) | (r_e.rd == rs2D));
  // Gated by reset so a redirect seen while held in reset never leaks out.
  assign w_flush = rst & PCSrcM;
  assign w_stall = w_ldu & ~w_flush;

  assign StallF    = w_stall;
  assign StallD    = w_stall;
  assign FlushD    = w_flush;
  assign FlushE    = w_flush | w_ldu;
  assign FlushM    = w_flush;
  assign state_o   = r_state;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

  // Source fields of M/W are tracked for completeness but nothing consumes them.
  assign w_unused = ^{r_m.rs1, r_m.rs2, r_w.rs1, r_w.rs2, r_w.memread};

  fwd_sel u_fwd_a (
    .i_m_valid    (r_m.valid),
    .i_m_regwrite (r_m.regwrite),
    .i_m_memread  (r_m.memread),
    .i_m_rd       (r_m.rd),
    .i_w_valid    (r_w.valid),
    .i_w_regwrite (r_w.regwrite),
    .i_w_rd       (r_w.rd),
    .i_rs         (r_e.rs1),
    .o_fwd        (ForwardAE)
  );

  fwd_sel u_fwd_b (
    .i_m_valid    (r_m.valid),
    .i_m_regwrite (r_m.regwrite),
    .i_m_memread  (r_m.memread),
    .i_m_rd       (r_m.rd),
    .i_w_valid    (r_w.valid),
    .i_w_regwrite (r_w.regwrite),
    .i_w_rd       (r_w.rd),
    .i_rs         (r_e.rs2),
    .o_fwd        (ForwardBE)
  );

  always_comb begin
    w_state_next = RUN;
    case (r_state)
      RUN: begin
        if (w_flush) begin
          w_state_next = FLUSH;
        end else if (w_ldu) begin
          w_state_next = STALL;
        end
      end
      STALL:   w_state_next = w_flush ? FLUSH : RUN;
      FLUSH:   w_state_next = RUN;
      default: w_state_next = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_e         <= '0;
      r_m         <= '0;
      r_w         <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_e <= (w_ldu | w_flush) ? '0 : w_d;
      r_m <= w_flush ? '0 : r_e;
      r_w <= r_m;
      if (w_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (w_flush && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized + directed scoreboard bench for hazard_ctrl against an instruction-level model.
module tb_hazard_ctrl;
  import core_pkg::*;

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       rw;
    logic       mr;
  } ins_t;

  typedef struct packed {
    logic        sf, sd, fd, fe, fm;
    logic [1:0]  fa, fb, st;
    logic [15:0] sc, fc;
    logic [1:0]  sc2, fc2;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, validD, RegWriteD, MemReadD, PCSrcM;
  logic [4:0]  rs1D, rs2D, rdD;
  logic        StallF, StallD, FlushD, FlushE, FlushM;
  logic [1:0]  ForwardAE, ForwardBE, state_o;
  logic [15:0] stall_cnt, flush_cnt;
  logic        s_StallF, s_StallD, s_FlushD, s_FlushE, s_FlushM;
  logic [1:0]  s_ForwardAE, s_ForwardBE, s_state_o;
  logic [1:0]  s_stall_cnt, s_flush_cnt;

  hazard_ctrl #(.CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .validD(validD), .rs1D(rs1D), .rs2D(rs2D), .rdD(rdD),
    .RegWriteD(RegWriteD), .MemReadD(MemReadD), .PCSrcM(PCSrcM),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .state_o(state_o),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // Narrow-counter twin on the same stimulus exposes saturation within a short run.
  hazard_ctrl #(.CNT_W(2)) u_dut_sat (
    .clk(clk), .rst(rst), .validD(validD), .rs1D(rs1D), .rs2D(rs2D), .rdD(rdD),
    .RegWriteD(RegWriteD), .MemReadD(MemReadD), .PCSrcM(PCSrcM),
    .StallF(s_StallF), .StallD(s_StallD), .FlushD(s_FlushD), .FlushE(s_FlushE),
    .FlushM(s_FlushM), .ForwardAE(s_ForwardAE), .ForwardBE(s_ForwardBE),
    .state_o(s_state_o), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  // flight[0] is in execute, [1] in memory, [2] in writeback.
  ins_t flight[$];
  int   mstate;
  int   n_stall, n_flush;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ins_t mk(input int rd, input int rs1, input int rs2,
                              input bit rw, input bit mr);
    ins_t r;
    r.v = 1'b1; r.rd = 5'(rd); r.rs1 = 5'(rs1); r.rs2 = 5'(rs2); r.rw = rw; r.mr = mr;
    return r;
  endfunction

  function automatic logic [31:0] sat(input int n, input int w);
    int mx;
    mx = (1 << w) - 1;
    return 32'((n > mx) ? mx : n);
  endfunction

  // Youngest older producer of rs wins; a load still in memory has no value to give yet.
  function automatic logic [1:0] fwd_for(input logic [4:0] rs);
    for (int age = 1; age <= 2; age++) begin
      ins_t p;
      p = flight[age];
      if (p.v && p.rw && p.rd != 0 && p.rd == rs && !(age == 1 && p.mr))
        return (age == 1) ? 2'b10 : 2'b01;
    end
    return 2'b00;
  endfunction

  task automatic reset_model();
    flight.delete();
    for (int i = 0; i < 3; i++) flight.push_back(ins_t'(0));
    mstate  = 0;
    n_stall = 0;
    n_flush = 0;
  endtask

  task automatic step(input ins_t d, input logic br);
    ins_t e, enter;
    exp_t x;
    logic hz, st;
    @(posedge clk);
    #1;
    validD = d.v; rdD = d.rd; rs1D = d.rs1; rs2D = d.rs2;
    RegWriteD = d.rw; MemReadD = d.mr; PCSrcM = br;
    e  = flight[0];
    hz = d.v && e.v && e.mr && e.rd != 0 && (e.rd == d.rs1 || e.rd == d.rs2);
    st = hz && !br;
    x.sf = st; x.sd = st; x.fd = br; x.fe = br || hz; x.fm = br;
    x.fa = fwd_for(e.rs1); x.fb = fwd_for(e.rs2); x.st = 2'(mstate);
    x.sc = 16'(sat(n_stall, 16)); x.fc = 16'(sat(n_flush, 16));
    x.sc2 = 2'(sat(n_stall, 2)); x.fc2 = 2'(sat(n_flush, 2));
    exp_q.push_back(x);
    enter = (hz || br) ? ins_t'(0) : d;
    flight.push_front(enter);
    if (br) flight[1] = ins_t'(0);
    void'(flight.pop_back());
    if (mstate == 2)   mstate = 0;
    else if (br)       mstate = 2;
    else if (hz && mstate == 0) mstate = 1;
    else               mstate = 0;
    if (st) n_stall++;
    if (br) n_flush++;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("StallF", 32'(StallF), 32'(e.sf));
      chk("StallD", 32'(StallD), 32'(e.sd));
      chk("FlushD", 32'(FlushD), 32'(e.fd));
      chk("FlushE", 32'(FlushE), 32'(e.fe));
      chk("FlushM", 32'(FlushM), 32'(e.fm));
      chk("ForwardAE", 32'(ForwardAE), 32'(e.fa));
      chk("ForwardBE", 32'(ForwardBE), 32'(e.fb));
      chk("state_o", 32'(state_o), 32'(e.st));
      chk("stall_cnt", 32'(stall_cnt), 32'(e.sc));
      chk("flush_cnt", 32'(flush_cnt), 32'(e.fc));
      chk("stall_cnt_w2", 32'(s_stall_cnt), 32'(e.sc2));
      chk("flush_cnt_w2", 32'(s_flush_cnt), 32'(e.fc2));
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_StallF"}, 32'(StallF), 0);
    chk({tag, "_StallD"}, 32'(StallD), 0);
    chk({tag, "_FlushD"}, 32'(FlushD), 0);
    chk({tag, "_FlushE"}, 32'(FlushE), 0);
    chk({tag, "_FlushM"}, 32'(FlushM), 0);
    chk({tag, "_FwdA"}, 32'(ForwardAE), 0);
    chk({tag, "_FwdB"}, 32'(ForwardBE), 0);
    chk({tag, "_state"}, 32'(state_o), 0);
    chk({tag, "_stall_cnt"}, 32'(stall_cnt), 0);
    chk({tag, "_flush_cnt"}, 32'(flush_cnt), 0);
    chk({tag, "_stall_cnt_w2"}, 32'(s_stall_cnt), 0);
  endtask

  initial begin
    ins_t nop, ld7, use7;
    nop  = ins_t'(0);
    ld7  = mk(7, 1, 0, 1, 1);
    use7 = mk(8, 0, 7, 1, 0);

    rst = 1'b0;
    validD = 1'b1; rdD = 5'd3; rs1D = 5'd3; rs2D = 5'd3;
    RegWriteD = 1'b1; MemReadD = 1'b1; PCSrcM = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    PCSrcM = 1'b0; validD = 1'b0;
    rst = 1'b1;
    reset_model();

    // Back-to-back ALU dependency forwards from M, one gap forwards from W.
    step(mk(5, 1, 2, 1, 0), 1'b0);
    step(mk(6, 5, 3, 1, 0), 1'b0);
    step(nop, 1'b0); sample(); chk("t1_fwdA_mem", 32'(ForwardAE), 32'(2'b10));
    step(mk(5, 1, 2, 1, 0), 1'b0);
    step(nop, 1'b0);
    step(mk(6, 5, 3, 1, 0), 1'b0);
    step(nop, 1'b0); sample(); chk("t1_fwdA_wb", 32'(ForwardAE), 32'(2'b01));

    // Load-use: one stall cycle, then forward from W.
    step(ld7, 1'b0);
    step(use7, 1'b0); sample();
    chk("t2_StallF", 32'(StallF), 1);
    chk("t2_FlushE", 32'(FlushE), 1);
    step(use7, 1'b0); sample();
    chk("t2_state", 32'(state_o), 1);
    chk("t2_stall_cnt", 32'(stall_cnt), 1);
    step(nop, 1'b0); sample(); chk("t2_fwdB_wb", 32'(ForwardBE), 32'(2'b01));

    // Redirect.
    step(mk(9, 1, 1, 1, 0), 1'b0);
    step(nop, 1'b1); sample();
    chk("t3_FlushD", 32'(FlushD), 1);
    chk("t3_FlushM", 32'(FlushM), 1);
    step(nop, 1'b0); sample();
    chk("t3_state", 32'(state_o), 2);
    chk("t3_flush_cnt", 32'(flush_cnt), 1);
    step(nop, 1'b0); sample(); chk("t3_state_run", 32'(state_o), 0);

    // Load-use coincident with redirect: flush wins.
    step(ld7, 1'b0);
    step(use7, 1'b1); sample();
    chk("t4_StallF", 32'(StallF), 0);
    chk("t4_FlushE", 32'(FlushE), 1);
    step(nop, 1'b0); sample(); chk("t4_stall_cnt", 32'(stall_cnt), 1);

    // x0 never forwards nor stalls.
    step(mk(0, 1, 0, 1, 0), 1'b0);
    step(mk(11, 0, 2, 1, 0), 1'b0);
    step(nop, 1'b0); sample(); chk("t5_fwdA_x0", 32'(ForwardAE), 0);
    step(mk(0, 1, 0, 1, 1), 1'b0);
    step(mk(11, 0, 2, 1, 0), 1'b0); sample(); chk("t5_no_stall", 32'(StallF), 0);

    // Three more stalls push the 2-bit twin past all-ones.
    for (int i = 0; i < 3; i++) begin
      step(ld7, 1'b0);
      step(use7, 1'b0);
      step(use7, 1'b0);
    end
    step(nop, 1'b0); sample(); chk("t6_sat", 32'(s_stall_cnt), 32'(2'b11));

    for (int i = 0; i < 1500; i++) begin
      ins_t r;
      r.v  = ($urandom_range(0, 7) != 0);
      r.rd = 5'($urandom_range(0, 3)); r.rs1 = 5'($urandom_range(0, 3));
      r.rs2 = 5'($urandom_range(0, 3));
      r.rw = ($urandom_range(0, 3) != 0); r.mr = ($urandom_range(0, 2) == 0);
      step(r, ($urandom_range(0, 9) == 0));
    end

    // Reset asserted in the middle of a stall.
    step(nop, 1'b0);
    step(ld7, 1'b0);
    step(use7, 1'b0);
    @(negedge clk);
    #2;
    PCSrcM = 1'b1;
    rst = 1'b0;
    #1;
    chk_all_zero("midrst");
    @(posedge clk);
    @(negedge clk);
    PCSrcM = 1'b0;
    rst = 1'b1;
    reset_model();
    step(use7, 1'b0); sample();
    chk("postrst_StallF", 32'(StallF), 0);
    chk("postrst_FlushE", 32'(FlushE), 0);
    repeat (20) step(mk($urandom_range(0, 3), $urandom_range(0, 3), 2, 1, 1), 1'b0);
    sample();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
